// File: rtl/sram_ctrl_pkg.sv
// Shared constants and helpers for the SRAM controller slice.
// Geometry defaults here are the single source for every block that touches the macro.
package sram_ctrl_pkg;
  localparam int DW     = 128;
  localparam int AW     = 11;
  localparam int NPORTS = 2;

  // Two-port round-robin pick: the pointer breaks ties, otherwise the lone requester wins.
  function automatic logic rr_pick(input logic [NPORTS-1:0] elig, input logic ptr);
    if (&elig) return ptr;
    return elig[1];
  endfunction
endpackage

// File: rtl/sram_rsp_slot.sv
// Per-port read response slot: tracks the in-flight read, captures SRAM data
// one cycle after the grant and holds it until the requester takes it.
module sram_rsp_slot #(
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd_grant,
  input  logic          rready,
  input  logic [DW-1:0] q,
  output logic          inflight,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
    end else begin
      inflight <= rd_grant;
      // A capture wins over a same-edge handshake so the new word is never lost.
      if (inflight) begin
        rdata  <= q;
        rvalid <= 1'b1;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro.
// Grants and SRAM controls are combinational; read data returns two cycles after grant.
module sram_port_arbiter #(
  parameter int DW = sram_ctrl_pkg::DW,
  parameter int AW = sram_ctrl_pkg::AW
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          p0_valid,
  output logic          p0_ready,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_rvalid,
  input  logic          p0_rready,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_valid,
  output logic          p1_ready,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_rvalid,
  input  logic          p1_rready,
  output logic [DW-1:0] p1_rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);
  import sram_ctrl_pkg::NPORTS;
  import sram_ctrl_pkg::rr_pick;

  logic [NPORTS-1:0]         valid, we, rready, rvalid, inflight, elig, gnt, rd_gnt;
  logic [NPORTS-1:0][AW-1:0] addr;
  logic [NPORTS-1:0][DW-1:0] wdata, rdata;
  logic                      ptr, gsel;

  assign valid  = {p1_valid, p0_valid};
  assign we     = {p1_we, p0_we};
  assign rready = {p1_rready, p0_rready};
  assign addr   = {p1_addr, p0_addr};
  assign wdata  = {p1_wdata, p0_wdata};

  for (genvar n = 0; n < NPORTS; n++) begin : g_port
    // Reads wait for the previous one to land and for the response slot to be free.
    assign elig[n] = valid[n] & (we[n] | (~inflight[n] & (~rvalid[n] | rready[n])));

    sram_rsp_slot #(.DW(DW)) u_slot (
      .clk      (CLK),
      .rst_n    (RSTN),
      .rd_grant (rd_gnt[n]),
      .rready   (rready[n]),
      .q        (sram_q),
      .inflight (inflight[n]),
      .rvalid   (rvalid[n]),
      .rdata    (rdata[n])
    );
  end

  assign gsel   = rr_pick(elig, ptr);
  assign gnt    = (|elig) ? (NPORTS'(1) << gsel) : '0;
  assign rd_gnt = gnt & ~we;

  always_comb begin
    sram_cen = 1'b1;
    sram_wen = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
    if (|gnt) begin
      sram_cen = 1'b0;
      sram_wen = ~we[gsel];
      sram_a   = addr[gsel];
      sram_d   = wdata[gsel];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)     ptr <= 1'b0;
    else if (|gnt) ptr <= ~ptr;
  end

  assign p0_ready  = gnt[0];
  assign p1_ready  = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rdata[0];
  assign p1_rdata  = rdata[1];
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized + directed bench for sram_port_arbiter with a queue-based reference model.
module tb_sram_port_arbiter;
  localparam int DW = 128;
  localparam int AW = 11;

  logic CLK = 1'b0;
  logic RSTN;
  always #5 CLK = ~CLK;

  logic          valid [2];
  logic          we    [2];
  logic          rready[2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ready [2];
  logic          rvalid[2];
  logic [DW-1:0] rdata [2];
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  sram_port_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .p0_valid(valid[0]), .p0_ready(ready[0]), .p0_we(we[0]), .p0_addr(addr[0]),
    .p0_wdata(wdata[0]), .p0_rvalid(rvalid[0]), .p0_rready(rready[0]), .p0_rdata(rdata[0]),
    .p1_valid(valid[1]), .p1_ready(ready[1]), .p1_we(we[1]), .p1_addr(addr[1]),
    .p1_wdata(wdata[1]), .p1_rvalid(rvalid[1]), .p1_rready(rready[1]), .p1_rdata(rdata[1]),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  // SRAM macro stand-in: q updates on the edge that samples a read.
  logic [DW-1:0] mem [0:2047];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  // Reference model: memory contents plus per-port queue of (due cycle, data).
  typedef struct { int due; logic [DW-1:0] data; } rsp_t;
  logic [DW-1:0] mem_ref [0:2047];
  rsp_t rq [2][$];
  int   ptr_m;
  int   cyc;
  int   exp_gnt;
  bit   chk_en;
  int   n_chk, n_fail;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RSTN && chk_en) begin
      bit vis [2];
      bit infl[2];
      bit el  [2];
      int g;
      for (int p = 0; p < 2; p++) begin
        vis[p]  = rq[p].size() > 0 && rq[p][0].due <= cyc;
        infl[p] = rq[p].size() > 0 && rq[p][rq[p].size()-1].due > cyc;
        el[p]   = valid[p] && (we[p] || (!infl[p] && (!vis[p] || rready[p])));
        chk($sformatf("p%0d_rvalid", p), rvalid[p], vis[p]);
        if (vis[p]) chk($sformatf("p%0d_rdata", p), rdata[p], rq[p][0].data);
      end
      g = (el[0] && el[1]) ? ptr_m : el[0] ? 0 : el[1] ? 1 : -1;
      for (int p = 0; p < 2; p++) chk($sformatf("p%0d_ready", p), ready[p], g == p);
      chk("sram_cen", sram_cen, g < 0);
      if (g >= 0) begin
        chk("sram_wen", sram_wen, !we[g]);
        chk("sram_a", sram_a, addr[g]);
        if (we[g]) chk("sram_d", sram_d, wdata[g]);
      end else begin
        chk("idle_wen", sram_wen, 1'b1);
        chk("idle_a", sram_a, '0);
        chk("idle_d", sram_d, '0);
      end
      for (int p = 0; p < 2; p++)
        if (vis[p] && rready[p]) void'(rq[p].pop_front());
      if (g >= 0) begin
        if (we[g]) mem_ref[addr[g]] = wdata[g];
        else       rq[g].push_back('{cyc + 2, mem_ref[addr[g]]});
        ptr_m = 1 - ptr_m;
      end
      exp_gnt = g;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    #2;
  endtask

  task automatic idle();
    for (int p = 0; p < 2; p++) valid[p] = 1'b0;
  endtask

  task automatic req(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    valid[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d;
  endtask

  // Called at posedge+1: asserts reset mid-cycle, holds it, releases at posedge+1.
  task automatic pulse_reset(input int hold);
    idle();
    #1 RSTN = 1'b0;
    #1;
    chk("rst_p0_rvalid", rvalid[0], 1'b0);
    chk("rst_p1_rvalid", rvalid[1], 1'b0);
    chk("rst_p0_rdata", rdata[0], '0);
    chk("rst_p1_rdata", rdata[1], '0);
    rq[0].delete(); rq[1].delete();
    ptr_m = 0; exp_gnt = -1;
    repeat (hold) step();
    RSTN = 1'b1;
  endtask

  localparam logic [DW-1:0] VA = 128'hAAAA_0001_2222_3333_4444_5555_6666_7777;
  localparam logic [DW-1:0] VB = 128'hBBBB_0002_1111_2222_3333_4444_5555_6666;
  localparam logic [DW-1:0] VC = 128'hCCCC_0003_9999_8888_7777_6666_5555_4444;

  initial begin
    logic prev;
    n_chk = 0; n_fail = 0; cyc = 0; ptr_m = 0; exp_gnt = -1; chk_en = 1'b0;
    for (int i = 0; i < 2048; i++) begin mem[i] = '0; mem_ref[i] = '0; end
    sram_q = '0;
    for (int p = 0; p < 2; p++) begin
      valid[p] = 0; we[p] = 0; addr[p] = '0; wdata[p] = '0; rready[p] = 1;
    end
    RSTN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_p0_rvalid", rvalid[0], 1'b0);
    chk("rst_p0_rdata", rdata[0], '0);
    RSTN = 1'b1;
    chk_en = 1'b1;

    // Simultaneous writes right after reset: port 0 first, then port 1.
    req(0, 1, 11'd5, VA); req(1, 1, 11'd6, VB);
    sample(); chk("w0_ready", ready[0], 1'b1); chk("w0_p1_ready", ready[1], 1'b0);
    chk("w0_a", sram_a, 11'd5); chk("w0_wen", sram_wen, 1'b0);
    step(); valid[0] = 0;
    sample(); chk("w1_ready", ready[1], 1'b1); chk("w1_a", sram_a, 11'd6); chk("w1_d", sram_d, VB);

    // Simple read with immediate consume.
    step(); idle(); req(0, 0, 11'd5, '0);
    sample(); chk("rd_ready", ready[0], 1'b1); chk("rd_wen", sram_wen, 1'b1);
    step(); idle(); sample(); chk("rd_c1_rvalid", rvalid[0], 1'b0);
    step(); sample(); chk("rd_c2_rvalid", rvalid[0], 1'b1); chk("rd_c2_rdata", rdata[0], VA);
    step(); sample(); chk("rd_c3_rvalid", rvalid[0], 1'b0);

    // Backpressure: response held, next read blocked until rready.
    step(); rready[0] = 0; req(0, 0, 11'd6, '0);
    sample(); chk("bp_ready", ready[0], 1'b1);
    step(); req(0, 0, 11'd5, '0); sample(); chk("bp_c1_ready", ready[0], 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(); sample();
      chk("bp_hold_rvalid", rvalid[0], 1'b1); chk("bp_hold_rdata", rdata[0], VB);
      chk("bp_hold_ready", ready[0], 1'b0);
    end
    step(); rready[0] = 1; sample(); chk("bp_rel_ready", ready[0], 1'b1);
    step(); idle(); sample(); chk("bp_gap_rvalid", rvalid[0], 1'b0);
    step(); sample(); chk("bp_next_rvalid", rvalid[0], 1'b1); chk("bp_next_rdata", rdata[0], VA);

    // Write behind an in-flight read to the same address returns the old value.
    step(); idle(); step(); req(0, 0, 11'd5, '0); sample(); chk("raw_rd_ready", ready[0], 1'b1);
    step(); idle(); req(1, 1, 11'd5, VC); sample(); chk("raw_wr_ready", ready[1], 1'b1);
    step(); idle(); sample(); chk("raw_rdata", rdata[0], VA); chk("raw_rvalid", rvalid[0], 1'b1);
    step(); req(0, 0, 11'd5, '0);
    step(); idle(); step(); sample(); chk("raw_after_rdata", rdata[0], VC);

    // Continuous reads on both ports alternate every cycle.
    step(); req(0, 0, 11'd6, '0); req(1, 0, 11'd5, '0);
    sample(); prev = ready[0];
    chk("alt_first_onehot", ready[0] ^ ready[1], 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(); sample();
      chk("alt_onehot", ready[0] ^ ready[1], 1'b1);
      chk("alt_toggle", ready[0], !prev);
      prev = ready[0];
    end

    // Reset while a read is in flight: no response afterwards, pointer back at port 0.
    step(); idle(); step(); step();
    req(0, 0, 11'd5, '0); sample(); chk("rst_rd_ready", ready[0], 1'b1);
    step(); pulse_reset(2);
    for (int i = 0; i < 4; i++) begin
      sample(); chk("post_rst_rvalid", rvalid[0], 1'b0); step();
    end
    req(0, 1, 11'd9, VB); req(1, 1, 11'd10, VA);
    sample(); chk("post_rst_ptr_p0", ready[0], 1'b1); chk("post_rst_ptr_p1", ready[1], 1'b0);
    step(); valid[0] = 0; step(); idle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset(int'($urandom_range(1, 3)));
      end else begin
        for (int p = 0; p < 2; p++) begin
          rready[p] = ($urandom_range(0, 3) != 0);
          if (!(valid[p] && exp_gnt != p)) begin
            valid[p] = ($urandom_range(0, 9) < 6);
            we[p]    = ($urandom_range(0, 9) < 4);
            addr[p]  = AW'($urandom_range(0, 7));
            wdata[p] = {$urandom, $urandom, $urandom, $urandom};
          end
        end
      end
    end
    step(); idle(); repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

Interface
REQ-001: Parameter DW, default 128, SRAM word width in bits.
REQ-002: Parameter AW, default 11, SRAM address width in bits (2048 words).
REQ-003: The block SHALL have one clock and an asynchronous active-low reset: CLK  input  1  rising-edge clock, shared with the SRAM macro.
REQ-004: RSTN  input  1  asynchronous active-low reset.
REQ-005: pN_valid  input  1  port N (N=0,1) request valid.
REQ-006: pN_ready  output  1  port N request accepted this cycle (combinational).
REQ-007: pN_we  input  1  port N request type (1 = write, 0 = read).
REQ-008: pN_addr  input  AW  port N word address.
REQ-009: pN_wdata  input  DW  port N write data.
REQ-010: pN_rvalid  output  1  port N read response valid (registered).
REQ-011: pN_rready  input  1  port N read response consumed.
REQ-012: pN_rdata  output  DW  port N read response data (registered).
REQ-013: sram_cen  output  1  SRAM chip enable, active low.
REQ-014: sram_wen  output  1  SRAM write enable, active low (1 = read).
REQ-015: sram_a  output  AW  SRAM address.
REQ-016: sram_d  output  DW  SRAM write data.
REQ-017: sram_q  input  DW  SRAM read data, valid from the clock edge after a read is sampled.

Function
REQ-018: Port N SHALL be eligible when pN_valid=1 and, for reads only, no read of port N is in flight and (pN_rvalid=0 or pN_rready=1).
REQ-019: At most one port SHALL be granted per cycle; grant g asserts pg_ready=1 in that cycle.
REQ-020: One eligible port SHALL be granted; with both eligible, the port selected by the round-robin pointer SHALL be granted.
REQ-021: After every grant, the pointer SHALL move to the other port; it SHALL hold when no grant occurs.
REQ-022: On a grant, sram_cen=0, sram_wen=~pg_we, sram_a=pg_addr, sram_d=pg_wdata SHALL be driven combinationally in the same cycle.
REQ-023: With no grant, sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
REQ-024: A read granted in cycle c SHALL set the port's in-flight flag at the end of c; sram_q SHALL be captured into pN_rdata at the end of c+1, with pN_rvalid=1 from cycle c+2 and in-flight cleared.
REQ-025: pN_rvalid SHALL stay high and pN_rdata stable until pN_rvalid=1 and pN_rready=1; it SHALL clear at that edge unless a capture occurs at the same edge, in which case it SHALL stay high with the new data.
REQ-026: Per-port read throughput is one read per 2 cycles; the other port SHALL be grantable in the intervening cycle.
REQ-027: Writes SHALL complete at the grant edge, with no response.
REQ-028: A write to an address whose read is in flight, granted in cycle c+1, SHALL NOT affect the captured data (the read returns the pre-write value).
REQ-029: A request with pN_valid=1 and pN_ready=0 SHALL be held stable by the requester; the block SHALL NOT drop or reorder it.

Reset
REQ-030: While RSTN=0: pN_rvalid=0, pN_rdata=0, in-flight flags=0, pointer=port 0; outputs SHALL take these values asynchronously.
REQ-031: A read in flight when RSTN asserts SHALL be discarded; no response SHALL appear after release.
REQ-032: The first cycle after RSTN deasserts SHALL accept requests normally.

Structure
REQ-033: DW, AW, and the port-count constant 2 SHALL reside in the shared package sram_ctrl_pkg.
REQ-034: One sub-module, sram_rsp_slot (capture register plus valid/ready holding for one port), SHALL be instantiated once per port.
REQ-035: The SRAM macro wrapper SHALL NOT be instantiated inside this block.

Verification
REQ-036: Both ports write simultaneously after reset (p0 addr 5 data A, p1 addr 6 data B) -> p0 granted in cycle 0, p1 in cycle 1; SRAM sees writes in that order.
REQ-037: p0 reads addr 5 in cycle c with p0_rready=1 -> p0_rvalid=1 in cycle c+2, p0_rdata=A, held 1 cycle.
REQ-038: p0 reads with p0_rready=0 for 4 cycles -> rvalid and rdata stay stable; a second p0 read is not granted until rready=1.
REQ-039: p0 reads addr 5 (value A) in cycle c; p1 writes C to addr 5 in cycle c+1 -> p0_rdata=A.
REQ-040: Continuous p0 and p1 reads -> grants alternate every cycle; each port receives one response per 2 cycles, in order.
REQ-041: RSTN pulsed low in cycle c+1 after a read grant in c -> no rvalid after release; pointer is at port 0.
